kw_stream_out: RTL and testbench

//  Parametrised kernel-weight streamer for conv layers; successor of the fixed 18-ch/25-tap weight fetcher.

---
 rtl/kw_pkg.sv | 29 ++
 rtl/kw_rom.sv | 52 +++++
 rtl/kw_stream_out.sv | 145 ++++++++++++++
 tb/tb_kw_stream_out.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kw_pkg.sv
// kw_pkg: shared definitions for the kernel-weight streamer.
//   kw_state_t  : streamer FSM states (IDLE/LOAD/RUN/DRAIN)
//   clog2       : address/counter width helper (never returns less than 1)
//   DEF_*       : default geometry of the conv-layer weight store
package kw_pkg;

    localparam int unsigned DEF_NUM_CH  = 18;
    localparam int unsigned DEF_DW      = 16;
    localparam int unsigned DEF_KLEN    = 25;
    localparam int unsigned DEF_NUM_SET = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } kw_state_t;

    // Width needed to index v entries; a 1-entry space still gets one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/kw_rom.sv
// kw_rom: single-port synchronous-read weight ROM for one channel.
//   clk_in : clock, rising edge
//   rst_n  : asynchronous reset, active high; clears the output register
//   en     : read enable; dout holds its value when low
//   addr   : word address
//   dout   : registered read data, one cycle after en
// Contents are the pattern CH_ID*4096 + addr (truncated to DW).
module kw_rom
    import kw_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned DEPTH    = DEF_NUM_SET * DEF_KLEN,
    parameter int unsigned AW       = clog2(DEPTH),
    parameter string       INIT_DIR = "",
    parameter int unsigned CH_ID    = 0
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout
);

    if (INIT_DIR == "") begin : g_pattern
        always_ff @(posedge clk_in or posedge rst_n) begin
            if (rst_n) begin
                dout <= '0;
            end else if (en) begin
                if (32'(addr) < DEPTH)
                    dout <= DW'(CH_ID * 4096) + DW'(addr);
                else
                    dout <= '0;
            end
        end
    end else begin : g_file
        logic [DW-1:0] mem [DEPTH];

        initial begin
            for (int unsigned a = 0; a < DEPTH; a++)
                mem[a] = DW'(CH_ID * 4096) + DW'(a);
        end

        always_ff @(posedge clk_in or posedge rst_n) begin
            if (rst_n) begin
                dout <= '0;
            end else if (en) begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/kw_stream_out.sv
// kw_stream_out: parametrised kernel-weight streamer for conv layers.
// Streams KLEN consecutive taps of one kernel set from NUM_CH parallel ROMs.
//   clk_in    : clock, rising edge
//   rst_n     : asynchronous reset, ACTIVE HIGH despite the name
//   start     : 1-cycle request, honoured only in IDLE
//   k_ind     : kernel-set index, latched with start
//   repeat_en : restart the same set after its last tap (sampled at each wrap)
//   abort     : synchronous stop, back to IDLE without done
//   k_ready   : downstream accepts a tap this cycle
//   k_data    : {ch[NUM_CH-1]..ch0} signed taps, channel n at [n*DW +: DW]
//   k_valid   : k_data carries a new tap
//   k_last    : with k_valid, tap KLEN-1 of the set
//   busy      : high outside IDLE
//   done      : 1-cycle pulse with the final valid of a non-repeating run
//   err_ind   : 1-cycle pulse when start is rejected (k_ind >= NUM_SET)
module kw_stream_out
    import kw_pkg::*;
#(
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned KLEN     = DEF_KLEN,
    parameter int unsigned NUM_SET  = DEF_NUM_SET,
    parameter int unsigned IW       = 6,
    parameter string       INIT_DIR = "kw/"
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [IW-1:0]        k_ind,
    input  logic                 repeat_en,
    input  logic                 abort,
    input  logic                 k_ready,
    output logic [NUM_CH*DW-1:0] k_data,
    output logic                 k_valid,
    output logic                 k_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err_ind
);

    localparam int unsigned DEPTH = NUM_SET * KLEN;
    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned CW    = clog2(KLEN);
    localparam logic [CW-1:0] LAST_TAP = CW'(KLEN - 1);

    kw_state_t     state;
    logic [IW-1:0] idx;
    logic [AW-1:0] base;
    logic [CW-1:0] cnt;
    logic          issue;
    logic          at_last;
    logic [AW-1:0] rd_addr;

    // A tap is issued whenever RUN meets k_ready; the ROM enable is the same
    // signal, so k_data freezes on every non-issue cycle.
    assign issue   = (state == RUN) && k_ready;
    assign at_last = (cnt == LAST_TAP);
    assign rd_addr = base + AW'(cnt);

    always_ff @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            base    <= '0;
            cnt     <= '0;
            k_valid <= 1'b0;
            k_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_ind <= 1'b0;
        end else begin
            // Flags track the ROM read latency: they describe the tap issued
            // in the previous cycle, including one issued during an abort.
            k_valid <= issue;
            k_last  <= issue && at_last;
            done    <= 1'b0;
            err_ind <= 1'b0;

            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (32'(k_ind) < NUM_SET) begin
                                idx   <= k_ind;
                                state <= LOAD;
                                busy  <= 1'b1;
                            end else begin
                                err_ind <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        base  <= AW'(idx) * AW'(KLEN);
                        cnt   <= '0;
                        state <= RUN;
                    end
                    RUN: begin
                        if (k_ready) begin
                            if (at_last) begin
                                cnt <= '0;
                                // done is raised on the same edge that raises
                                // the final k_valid, so both appear together.
                                if (!repeat_en) begin
                                    state <= DRAIN;
                                    done  <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        kw_rom #(
            .DW       (DW),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .INIT_DIR (INIT_DIR),
            .CH_ID    (n)
        ) u_rom (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .en     (issue),
            .addr   (rd_addr),
            .dout   (k_data[n*DW +: DW])
        );
    end

endmodule

// File: tb/tb_kw_stream_out.sv
module tb_kw_stream_out;

    localparam int unsigned NCH    = 18;
    localparam int unsigned DW     = 16;
    localparam int unsigned KLEN   = 25;
    localparam int unsigned NCH_C  = 4;
    localparam int unsigned KLEN_C = 9;
    localparam int unsigned IW     = 6;
    localparam int unsigned BW     = NCH * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, repeat_en, abort, k_ready;
    logic [IW-1:0] k_ind;
    int unsigned   sel;
    logic          start_a, start_b, start_c;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    logic [BW-1:0]       data_a, data_b;
    logic [NCH_C*DW-1:0] data_c;
    logic valid_a, last_a, busy_a, done_a, err_a;
    logic valid_b, last_b, busy_b, done_b, err_b;
    logic valid_c, last_c, busy_c, done_c, err_c;

    kw_stream_out #(.INIT_DIR("")) u_a (
        .clk_in(clk), .rst_n(rst), .start(start_a), .k_ind(k_ind), .repeat_en(repeat_en),
        .abort(abort), .k_ready(k_ready), .k_data(data_a), .k_valid(valid_a), .k_last(last_a),
        .busy(busy_a), .done(done_a), .err_ind(err_a));

    kw_stream_out #(.NUM_SET(40), .INIT_DIR("")) u_b (
        .clk_in(clk), .rst_n(rst), .start(start_b), .k_ind(k_ind), .repeat_en(repeat_en),
        .abort(abort), .k_ready(k_ready), .k_data(data_b), .k_valid(valid_b), .k_last(last_b),
        .busy(busy_b), .done(done_b), .err_ind(err_b));

    kw_stream_out #(.NUM_CH(NCH_C), .KLEN(KLEN_C), .INIT_DIR("")) u_c (
        .clk_in(clk), .rst_n(rst), .start(start_c), .k_ind(k_ind), .repeat_en(repeat_en),
        .abort(abort), .k_ready(k_ready), .k_data(data_c), .k_valid(valid_c), .k_last(last_c),
        .busy(busy_c), .done(done_c), .err_ind(err_c));

    logic [BW-1:0] obs_data;
    logic obs_valid, obs_last, obs_busy, obs_done, obs_err;

    always_comb begin
        obs_data  = data_a;
        obs_valid = valid_a;
        obs_last  = last_a;
        obs_busy  = busy_a;
        obs_done  = done_a;
        obs_err   = err_a;
        if (sel == 1) begin
            obs_data  = data_b;
            obs_valid = valid_b;
            obs_last  = last_b;
            obs_busy  = busy_b;
            obs_done  = done_b;
            obs_err   = err_b;
        end else if (sel == 2) begin
            obs_data  = BW'(data_c);
            obs_valid = valid_c;
            obs_last  = last_c;
            obs_busy  = busy_c;
            obs_done  = done_c;
            obs_err   = err_c;
        end
    end

    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;
    logic [BW-1:0] held [3];

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%b expected=%b", tag, sel, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    // Reference tap: channel c at ROM address a holds c*4096 + a, truncated to DW bits.
    function automatic logic [BW-1:0] model_tap(input int unsigned s, input int unsigned addr);
        logic [BW-1:0] v;
        int unsigned   nch;
        v   = '0;
        nch = (s == 2) ? NCH_C : NCH;
        for (int unsigned c = 0; c < nch; c++) v[c*DW +: DW] = 16'((c * 4096 + addr) % 65536);
        return v;
    endfunction

    // One start on DUT s with set idx, 'sets' passes (repeat held until mid last pass).
    // rdy_mode: 0 = always ready, 1 = random, 2 = pattern 1,0,0.
    // abort_at: nonzero -> abort in the cycle of that issue. pester: extra start while busy.
    task automatic run(input int unsigned s, input int unsigned idx, input int unsigned sets,
                       input int unsigned rdy_mode, input int unsigned abort_at, input bit pester);
        int unsigned klen, total, issued, pend_addr, tail;
        bit pend, pend_last, pend_final, finished, ok;
        klen     = (s == 2) ? KLEN_C : KLEN;
        total    = sets * klen;
        issued   = 0;
        pend     = 0;
        pend_last  = 0;
        pend_final = 0;
        pend_addr  = 0;
        finished = 0;
        ok       = 0;
        tail     = 0;
        sel      = s;
        for (int unsigned k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (pend) held[s] = model_tap(s, pend_addr);
            chk_bit("k_valid", obs_valid, pend);
            chk_bit("k_last", obs_last, pend && pend_last);
            chk_vec("k_data", obs_data, held[s]);
            chk_bit("busy", obs_busy, (k >= 1) && !finished);
            chk_bit("done", obs_done, pend && pend_final);
            chk_bit("err_ind", obs_err, 1'b0);
            if (pend && pend_final) finished = 1;
            if (finished) begin
                tail++;
                if (tail > 3) begin
                    ok = 1;
                    break;
                end
            end
            start = (k == 0) || (pester && k == 6);
            if (k == 0) k_ind = IW'(idx);
            else if (start) k_ind = IW'($urandom_range(0, 63));
            case (rdy_mode)
                0:       k_ready = 1'b1;
                1:       k_ready = 1'($urandom_range(0, 1));
                default: k_ready = (k % 3 == 0);
            endcase
            repeat_en = (sets > 1) && (issued < (sets - 1) * klen + klen / 2);
            abort     = 1'b0;
            pend       = 0;
            pend_final = 0;
            if (k >= 2 && !finished && issued < total) begin
                if (abort_at != 0 && issued + 1 == abort_at) begin
                    k_ready = 1'b1;
                    abort   = 1'b1;
                end
                if (k_ready) begin
                    pend      = 1;
                    pend_addr = idx * klen + issued % klen;
                    pend_last = (issued % klen) == klen - 1;
                    issued++;
                    pend_final = (issued == total) && !abort;
                end
                if (abort) finished = 1;
            end
        end
        chk_bit("run_terminates", ok, 1'b1);
        start     = 1'b0;
        abort     = 1'b0;
        repeat_en = 1'b0;
        k_ready   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; repeat_en = 1'b0; abort = 1'b0; k_ready = 1'b0;
        k_ind = '0; sel = 0;
        for (int i = 0; i < 3; i++) held[i] = '0;
        #1;
        for (int unsigned s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_vec("rst_k_data", obs_data, '0);
            chk_bit("rst_k_valid", obs_valid, 1'b0);
            chk_bit("rst_k_last", obs_last, 1'b0);
            chk_bit("rst_busy", obs_busy, 1'b0);
            chk_bit("rst_done", obs_done, 1'b0);
            chk_bit("rst_err", obs_err, 1'b0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(0, 3, 1, 0, 0, 0);
        run(0, 63, 1, 1, 0, 0);
        run(0, 10, 1, 2, 0, 0);
        run(0, 2, 3, 0, 0, 0);
        run(0, 2, 2, 1, 0, 0);
        run(0, $urandom_range(0, 63), 1, 1, 10, 1);
        run(0, 20, 1, 0, 0, 1);

        // Range check on the NUM_SET=40 build.
        sel = 1;
        @(negedge clk); start = 1'b1; k_ind = 6'd40;
        @(negedge clk); start = 1'b0;
        chk_bit("err_pulse", obs_err, 1'b1);
        chk_bit("err_busy", obs_busy, 1'b0);
        @(negedge clk);
        chk_bit("err_clear", obs_err, 1'b0);
        chk_bit("err_busy2", obs_busy, 1'b0);
        start = 1'b1; k_ind = 6'd63;
        @(negedge clk); start = 1'b0;
        chk_bit("err_pulse63", obs_err, 1'b1);
        run(1, 39, 1, 1, 0, 0);
        run(1, 0, 2, 0, 0, 0);

        // abort and start together in IDLE: start dropped.
        sel = 0;
        @(negedge clk); start = 1'b1; abort = 1'b1; k_ind = 6'd4;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk_bit("abort_start_busy", obs_busy, 1'b0);
        chk_bit("abort_start_err", obs_err, 1'b0);
        @(negedge clk);
        chk_bit("abort_start_busy2", obs_busy, 1'b0);
        chk_bit("abort_start_valid", obs_valid, 1'b0);

        run(2, 5, 1, 1, 0, 0);
        run(2, 63, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) run(0, $urandom_range(0, 63), $urandom_range(1, 2), 1, 0, 0);

        // Asynchronous reset in the middle of a stream.
        sel = 0;
        @(negedge clk); start = 1'b1; k_ind = 6'd7; k_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_vec("arst_k_data", obs_data, '0);
        chk_bit("arst_k_valid", obs_valid, 1'b0);
        chk_bit("arst_busy", obs_busy, 1'b0);
        chk_bit("arst_done", obs_done, 1'b0);
        for (int i = 0; i < 3; i++) held[i] = '0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bit("arst_after_valid", obs_valid, 1'b0);
            chk_bit("arst_after_busy", obs_busy, 1'b0);
            chk_bit("arst_after_done", obs_done, 1'b0);
        end
        k_ready = 1'b0;
        run(0, 1, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
